// File: rtl/rs_pkg.sv
// Shared constants, state type and GF(2^8) helper for the RS(204,188) encoder.
package rs_pkg;

    localparam int N_MSG = 188;
    localparam int N_PAR = 16;

    localparam logic [8:0] POLY = 9'h11D;

    // g(x) coefficients, index i is the coefficient of x^i (x^16 term is implicit 1).
    localparam logic [7:0] G_COEF [0:15] = '{
        8'd59,  8'd36,  8'd50,  8'd98,  8'd229, 8'd41,  8'd65,  8'd163,
        8'd8,   8'd30,  8'd209, 8'd68,  8'd189, 8'd104, 8'd13,  8'd59
    };

    typedef enum logic {
        MSG = 1'b0,
        PAR = 1'b1
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_mul_const.sv
// Multiply a GF(2^8) byte by a fixed constant; folds to a pure XOR network.
module gf_mul_const
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] operand,
    output logic [7:0] product
);

    assign product = gf_mul(operand, C);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(204,188) encoder: message bytes pass through, then 16 parity
// bytes are shifted out of an LFSR that divides by g(x).
module rs_encoder
    import rs_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] In_Data,
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic [7:0] Out_Data,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic       Out_Sop,
    output logic       Out_Eop
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic       out_free;
    logic       accept;
    logic       emit;
    logic [7:0] fb;
    logic [7:0] lfsr [0:N_PAR-1];
    logic [7:0] prod [0:N_PAR-1];

    assign out_free = !Out_Valid || Out_Ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        In_Ready  = 1'b0;
        accept    = 1'b0;
        emit      = 1'b0;
        case (state)
            MSG: begin
                In_Ready = out_free;
                accept   = In_Valid && out_free;
                if (accept) begin
                    if (count == 8'(N_MSG - 1)) begin
                        state_nxt = PAR;
                        count_nxt = 8'd0;
                    end else begin
                        count_nxt = count + 8'd1;
                    end
                end
            end
            PAR: begin
                emit = out_free;
                if (emit) begin
                    if (count == 8'(N_PAR - 1)) begin
                        state_nxt = MSG;
                        count_nxt = 8'd0;
                    end else begin
                        count_nxt = count + 8'd1;
                    end
                end
            end
            default: state_nxt = MSG;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= MSG;
            count <= 8'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Zero feedback while emitting parity turns the division into a plain shift with zero fill.
    assign fb = (state == MSG) ? (In_Data ^ lfsr[N_PAR-1]) : 8'h00;

    for (genvar i = 0; i < N_PAR; i++) begin : g_mul
        gf_mul_const #(.C(G_COEF[i])) u_mul (
            .operand(fb),
            .product(prod[i])
        );
    end

    // NOTE: the LFSR is 16 flip-flop bytes, not a RAM, so it is reset like any other state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_PAR; i++) lfsr[i] <= 8'h00;
        end else if (accept || emit) begin
            lfsr[0] <= prod[0];
            for (int i = 1; i < N_PAR; i++) lfsr[i] <= lfsr[i-1] ^ prod[i];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out_Data  <= 8'h00;
            Out_Valid <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
        end else if (accept) begin
            Out_Data  <= In_Data;
            Out_Valid <= 1'b1;
            Out_Sop   <= (count == 8'd0);
            Out_Eop   <= 1'b0;
        end else if (emit) begin
            Out_Data  <= lfsr[N_PAR-1];
            Out_Valid <= 1'b1;
            Out_Sop   <= 1'b0;
            Out_Eop   <= (count == 8'(N_PAR - 1));
        end else if (out_free) begin
            Out_Valid <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
        end
    end

endmodule
